ikaopll_wrseq: RTL

Host-side register-write sequencer for the IKAOPLL core. It buffers (address, data) register-write requests in a small FIFO. It replays each request onto the chip's CPU bus pins (CS_n, WR_n, A0, D) as an address write followed by a data write. Between strobes it enforces the YM2413 minimum wait times, counted in phiM cycles. It sits between a soft CPU or sound-driver FSM and the IKAOPLL bus inputs, so software never has to poll or time its writes.

---
 rtl/ikaopll_wrseq_if.sv | 25 ++
 rtl/ikaopll_wrseq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_wrseq_if.sv
// Request side of the IKAOPLL write sequencer: push handshake, payload and flush.
// The sound driver owns the master modport, the sequencer the slave modport.
interface ikaopll_wrseq_if;
    logic       i_REQ_VALID;
    logic       o_REQ_READY;
    logic [7:0] i_REQ_ADDR;
    logic [7:0] i_REQ_DATA;
    logic       i_FLUSH;

    modport master (
        output i_REQ_VALID,
        output i_REQ_ADDR,
        output i_REQ_DATA,
        output i_FLUSH,
        input  o_REQ_READY
    );

    modport slave (
        input  i_REQ_VALID,
        input  i_REQ_ADDR,
        input  i_REQ_DATA,
        input  i_FLUSH,
        output o_REQ_READY
    );
endinterface

// File: rtl/ikaopll_wrseq.sv
// Buffers (address, data) register writes and replays them onto the IKAOPLL CPU bus,
// with the chip's strobe widths and recovery gaps timed in enabled phiM cycles.
//
// state  | meaning
// IDLE   | bus released; pops the head entry once it is available
// ASTB   | address strobe low, A0=0, D=address
// AWAIT  | strobes high, address-phase recovery
// DSTB   | data strobe low, A0=1, D=data
// DWAIT  | strobes high, data-phase recovery
module ikaopll_wrseq #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int STROBE_LEN      = 4,
    parameter int ADDR_WAIT       = 12,
    parameter int DATA_WAIT       = 84
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST_n,
    input  logic                     i_phiM_PCEN_n,
    ikaopll_wrseq_if.slave           req,
    output logic                     o_BUSY,
    output logic [FIFO_DEPTH_LOG2:0] o_LEVEL,
    output logic                     o_CS_n,
    output logic                     o_WR_n,
    output logic                     o_A0,
    output logic [7:0]               o_D
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [7:0] STB_LOAD = 8'(STROBE_LEN - 1);
    localparam logic [7:0] AW_LOAD  = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DW_LOAD  = 8'(DATA_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ASTB  = 3'd1,
        S_AWAIT = 3'd2,
        S_DSTB  = 3'd3,
        S_DWAIT = 3'd4
    } state_t;

    logic [15:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
    logic                       avail_q, avail_d;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       cs_n_q, cs_n_d;
    logic       a0_q, a0_d;
    logic [7:0] d_q, d_d;

    logic enable;
    logic full;
    logic ready;
    logic push;
    logic pop;

    assign enable = ~i_phiM_PCEN_n;
    // level never exceeds DEPTH, so its MSB alone marks full
    assign full   = level_q[FIFO_DEPTH_LOG2];
    assign ready  = ~full & ~req.i_FLUSH;
    assign push   = req.i_REQ_VALID & ready;
    // an entry becomes poppable one clock after it lands (avail_q lags the level)
    assign pop    = enable & (state_q == S_IDLE) & avail_q & (level_q != '0) & ~req.i_FLUSH;

    assign req.o_REQ_READY = ready;
    assign o_LEVEL = level_q;
    assign o_BUSY  = (state_q != S_IDLE) | (level_q != '0);
    assign o_CS_n  = cs_n_q;
    assign o_WR_n  = cs_n_q;
    assign o_A0    = a0_q;
    assign o_D     = d_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        avail_d  = (level_q != '0) & ~req.i_FLUSH;
        if (req.i_FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (push) mem_q[wr_ptr_q] <= {req.i_REQ_ADDR, req.i_REQ_DATA};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {addr_d, data_d} = mem_q[rd_ptr_q];
                        cnt_d   = STB_LOAD;
                        state_d = S_ASTB;
                    end
                end
                S_ASTB: begin
                    if (cnt_q == '0) begin
                        cnt_d   = AW_LOAD;
                        state_d = S_AWAIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_AWAIT: begin
                    if (cnt_q == '0) begin
                        cnt_d   = STB_LOAD;
                        state_d = S_DSTB;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DSTB: begin
                    if (cnt_q == '0) begin
                        cnt_d   = DW_LOAD;
                        state_d = S_DWAIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DWAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // bus pins decode from the next state; A0/D move only on strobe entry
    always_comb begin
        cs_n_d = ~((state_d == S_ASTB) | (state_d == S_DSTB));
        a0_d   = a0_q;
        d_d    = d_q;
        if (state_d == S_ASTB) begin
            a0_d = 1'b0;
            d_d  = addr_d;
        end else if (state_d == S_DSTB) begin
            a0_d = 1'b1;
            d_d  = data_d;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            avail_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cs_n_q   <= 1'b1;
            a0_q     <= 1'b0;
            d_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            avail_q  <= avail_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cs_n_q   <= cs_n_d;
            a0_q     <= a0_d;
            d_q      <= d_d;
        end
    end

endmodule
